// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: N-to-1 AXI4-Stream packet arbiter with round-robin grant.
// One whole packet is forwarded per grant. A single idle cycle separates
// packets, and the downstream TVALID stays low until the first clock edge
// after reset release.
module axis_rr_arbiter #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int IDW    = $clog2(N)
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [N-1:0]        S_TVALID,
    output logic [N-1:0]        S_TREADY,
    input  logic [N*DATA_W-1:0] S_TDATA,
    input  logic [N-1:0]        S_TLAST,
    output logic                M_TVALID,
    input  logic                M_TREADY,
    output logic [DATA_W-1:0]   M_TDATA,
    output logic                M_TLAST,
    output logic [IDW-1:0]      M_TID,
    output logic                BUSY
);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_IDLE,
        ST_LOCK
    } state_t;

    state_t             state_q, state_d;
    logic               started_q, started_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic               pick_valid;
    logic [IDW-1:0]     pick_idx;
    logic [IDW-1:0]     cand_idx;
    logic               in_lock;
    logic               beat_done;
    logic [DATA_W-1:0]  s_data [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign s_data[g] = S_TDATA[g*DATA_W +: DATA_W];
    end

    // Round-robin search: first requester after the last served index, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            cand_idx = IDW'((int'(rr_ptr_q) + k) % N);
            if (!pick_valid && S_TVALID[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // State register; reset parks the arbiter in HOLD with slave 0 first in line.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= ST_HOLD;
            started_q <= 1'b0;
            grant_q   <= '0;
            rr_ptr_q  <= IDW'(N - 1);
        end else begin
            state_q   <= state_d;
            started_q <= started_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Next-state logic and stream muxing; outputs are forced quiet during reset and HOLD.
    always_comb begin
        state_d   = state_q;
        started_d = started_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        S_TREADY  = '0;

        in_lock   = ARESETn && started_q && (state_q == ST_LOCK);
        M_TVALID  = in_lock & S_TVALID[grant_q];
        M_TLAST   = in_lock & S_TLAST[grant_q];
        M_TDATA   = s_data[grant_q];
        M_TID     = grant_q;
        BUSY      = in_lock;
        if (in_lock) begin
            S_TREADY[grant_q] = M_TREADY;
        end
        beat_done = M_TVALID & M_TREADY & M_TLAST;

        case (state_q)
            ST_HOLD: begin
                started_d = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (beat_done) begin
                    rr_ptr_d = grant_q;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

endmodule
